// File: rtl/mc_b_drain.sv
// Snoops memory-B writes into a private result buffer and, on Start, streams the
// captured words out in ascending address order with a running checksum and count.
module mc_b_drain #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                     clock,
    input  logic                     Reset,
    input  logic                     WEB,
    input  logic [ADDR_W-1:0]        AddrB,
    input  logic [DATA_W-1:0]        DataInB,
    input  logic                     Start,
    output logic [DATA_W-1:0]        DOut,
    output logic                     DValid,
    input  logic                     DReady,
    output logic                     Busy,
    output logic                     DrainDone,
    output logic                     StartErr,
    output logic                     Overrun,
    output logic [DATA_W+ADDR_W-1:0] Checksum,
    output logic [ADDR_W:0]          Count
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] DRAIN   = 1'b1;

    logic [0:0]               state;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]         mask;
    logic [ADDR_W-1:0]        ptr;
    logic [DATA_W-1:0]        dout;
    logic                     dvalid;
    logic                     drain_done;
    logic                     start_err;
    logic                     overrun;
    logic [DATA_W+ADDR_W-1:0] checksum;
    logic [ADDR_W:0]          count;

    logic [DEPTH-1:0]         wr_bit;
    logic [DEPTH-1:0]         mask_in;
    logic [DEPTH-1:0]         mask_rest;
    logic [ADDR_W-1:0]        first;
    logic [ADDR_W-1:0]        next;
    logic [DATA_W-1:0]        first_word;

    function automatic logic [ADDR_W-1:0] lowest(input logic [DEPTH-1:0] m);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m[i]) idx = ADDR_W'(i);
        end
        return idx;
    endfunction

    // A write in the Start cycle must be visible to the first word, so forward it.
    always_comb begin
        wr_bit = '0;
        if (WEB) wr_bit[AddrB] = 1'b1;
        mask_in    = mask | wr_bit;
        first      = lowest(mask_in);
        first_word = (WEB && (AddrB == first)) ? DataInB : mem[first];
        mask_rest  = mask & ~(DEPTH'(1) << ptr);
        next       = lowest(mask_rest);
    end

    always_ff @(posedge clock) begin
        if (state == COLLECT && WEB) mem[AddrB] <= DataInB;
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state      <= COLLECT;
            mask       <= '0;
            ptr        <= '0;
            dout       <= '0;
            dvalid     <= 1'b0;
            drain_done <= 1'b0;
            start_err  <= 1'b0;
            overrun    <= 1'b0;
            checksum   <= '0;
            count      <= '0;
        end else begin
            drain_done <= 1'b0;
            start_err  <= 1'b0;
            if (state == COLLECT) begin
                mask <= mask_in;
                if (Start) begin
                    if (|mask_in) begin
                        state    <= DRAIN;
                        ptr      <= first;
                        dout     <= first_word;
                        dvalid   <= 1'b1;
                        checksum <= '0;
                        count    <= '0;
                        overrun  <= 1'b0;
                    end else begin
                        start_err <= 1'b1;
                    end
                end
            end else begin
                if (WEB) overrun <= 1'b1;
                if (dvalid && DReady) begin
                    checksum <= checksum + (DATA_W+ADDR_W)'(dout);
                    count    <= count + 1'b1;
                    mask     <= mask_rest;
                    if (|mask_rest) begin
                        ptr  <= next;
                        dout <= mem[next];
                    end else begin
                        dvalid     <= 1'b0;
                        state      <= COLLECT;
                        drain_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign DOut      = dout;
    assign DValid    = dvalid;
    assign Busy      = (state == DRAIN);
    assign DrainDone = drain_done;
    assign StartErr  = start_err;
    assign Overrun   = overrun;
    assign Checksum  = checksum;
    assign Count     = count;

endmodule

// File: tb/tb_mc_b_drain.sv
// Directed bench for mc_b_drain: queue-based reference model checked every cycle,
// plus literal expectations on drained words, checksum and count.
module tb_mc_b_drain;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       WEB = 1'b0;
    logic [1:0] AddrB = '0;
    logic [7:0] DataInB = '0;
    logic       Start = 1'b0;
    logic       DReady = 1'b0;
    logic [7:0] DOut;
    logic       DValid, Busy, DrainDone, StartErr, Overrun;
    logic [9:0] Checksum;
    logic [2:0] Count;

    mc_b_drain #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
        .clock(clock), .Reset(Reset), .WEB(WEB), .AddrB(AddrB), .DataInB(DataInB),
        .Start(Start), .DOut(DOut), .DValid(DValid), .DReady(DReady), .Busy(Busy),
        .DrainDone(DrainDone), .StartErr(StartErr), .Overrun(Overrun),
        .Checksum(Checksum), .Count(Count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered words per address, drained as an ordered queue.
    logic [7:0] m_buf [4];
    bit         m_valid [4];
    bit         m_drain = 0;
    bit         armed = 0;
    logic [7:0] q [$];
    logic [7:0] e_dout = '0;
    bit         e_dvalid = 0, e_busy = 0, e_done = 0, e_err = 0, e_ovr = 0;
    int         e_sum = 0, e_cnt = 0;

    always @(posedge clock) begin
        if (Reset) begin
            armed = 1;
            m_drain = 0;
            for (int i = 0; i < 4; i++) m_valid[i] = 0;
            q.delete();
            e_dout = '0; e_dvalid = 0; e_done = 0; e_err = 0; e_ovr = 0;
            e_sum = 0; e_cnt = 0;
        end else begin
            e_done = 0;
            e_err = 0;
            if (!m_drain) begin
                if (WEB) begin
                    m_buf[AddrB] = DataInB;
                    m_valid[AddrB] = 1;
                end
                if (Start) begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_valid[i]) begin
                            q.push_back(m_buf[i]);
                            m_valid[i] = 0;
                        end
                    end
                    if (q.size() > 0) begin
                        m_drain = 1;
                        e_sum = 0; e_cnt = 0; e_ovr = 0;
                        e_dvalid = 1;
                        e_dout = q[0];
                    end else begin
                        e_err = 1;
                    end
                end
            end else begin
                if (WEB) e_ovr = 1;
                if (e_dvalid && DReady) begin
                    e_sum = e_sum + int'(q[0]);
                    e_cnt = e_cnt + 1;
                    void'(q.pop_front());
                    if (q.size() > 0) begin
                        e_dout = q[0];
                    end else begin
                        e_dvalid = 0;
                        m_drain = 0;
                        e_done = 1;
                    end
                end
            end
        end
        e_busy = m_drain;
    end

    logic [7:0] got [$];

    always @(negedge clock) begin
        if (armed) begin
            chk("DValid", 32'(DValid), 32'(e_dvalid));
            chk("Busy", 32'(Busy), 32'(e_busy));
            chk("DrainDone", 32'(DrainDone), 32'(e_done));
            chk("StartErr", 32'(StartErr), 32'(e_err));
            chk("Overrun", 32'(Overrun), 32'(e_ovr));
            chk("Checksum", 32'(Checksum), 32'(e_sum));
            chk("Count", 32'(Count), 32'(e_cnt));
            if (e_dvalid) chk("DOut", 32'(DOut), 32'(e_dout));
            if (DValid && DReady) got.push_back(DOut);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        WEB = 1'b1; AddrB = a; DataInB = d;
        tick();
        WEB = 1'b0;
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && !DrainDone; i++) tick();
        chk({tag, "_done"}, 32'(DrainDone), 32'd1);
    endtask

    task automatic expect_words(input string tag, input int n,
                                input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        chk({tag, "_nwords"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk({tag, "_word"}, 32'(got[i]), 32'(w[i]));
            else chk({tag, "_missing"}, 32'hFFFF_FFFF, 32'(w[i]));
        end
    endtask

    initial begin
        // Test 1: full buffer, back-to-back drain.
        tick(); tick();
        Reset = 1'b0;
        chk("rst_dvalid", 32'(DValid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_sum", 32'(Checksum), 32'd0);
        wr(2'd0, 8'h05); wr(2'd1, 8'hFA); wr(2'd2, 8'h10); wr(2'd3, 8'h03);
        DReady = 1'b1;
        got.delete();
        start_pulse();
        wait_done("t1");
        expect_words("t1", 4, 8'h05, 8'hFA, 8'h10, 8'h03);
        chk("t1_sum", 32'(Checksum), 32'h112);
        chk("t1_count", 32'(Count), 32'd4);
        tick();
        chk("t1_done_once", 32'(DrainDone), 32'd0);

        // Test 2: stall while FA is presented.
        wr(2'd0, 8'h05); wr(2'd1, 8'hFA); wr(2'd2, 8'h10); wr(2'd3, 8'h03);
        got.delete();
        start_pulse();
        tick();
        DReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_dout", 32'(DOut), 32'hFA);
            chk("t2_hold_valid", 32'(DValid), 32'd1);
        end
        DReady = 1'b1;
        wait_done("t2");
        expect_words("t2", 4, 8'h05, 8'hFA, 8'h10, 8'h03);
        chk("t2_sum", 32'(Checksum), 32'h112);

        // Test 3: sparse entries, last write wins.
        wr(2'd1, 8'h7F); wr(2'd3, 8'h80); wr(2'd1, 8'h01);
        got.delete();
        start_pulse();
        wait_done("t3");
        expect_words("t3", 2, 8'h01, 8'h80, 8'h00, 8'h00);
        chk("t3_count", 32'(Count), 32'd2);
        chk("t3_sum", 32'(Checksum), 32'h081);

        // Test 4: Start on empty buffer after reset.
        Reset = 1'b1; tick(); Reset = 1'b0;
        start_pulse();
        chk("t4_err", 32'(StartErr), 32'd1);
        chk("t4_busy", 32'(Busy), 32'd0);
        tick();
        chk("t4_err_pulse", 32'(StartErr), 32'd0);
        wr(2'd2, 8'h44);
        got.delete();
        start_pulse();
        wait_done("t4");
        expect_words("t4", 1, 8'h44, 8'h00, 8'h00, 8'h00);

        // Test 5: write during drain sets sticky Overrun.
        wr(2'd0, 8'h11); wr(2'd1, 8'h22);
        DReady = 1'b0;
        got.delete();
        start_pulse();
        wr(2'd0, 8'hAA);
        chk("t5_ovr", 32'(Overrun), 32'd1);
        tick();
        chk("t5_ovr_sticky", 32'(Overrun), 32'd1);
        DReady = 1'b1;
        wait_done("t5");
        chk("t5_ovr_after", 32'(Overrun), 32'd1);
        expect_words("t5", 2, 8'h11, 8'h22, 8'h00, 8'h00);
        wr(2'd3, 8'h55);
        got.delete();
        start_pulse();
        chk("t5_ovr_clr", 32'(Overrun), 32'd0);
        wait_done("t5b");
        expect_words("t5b", 1, 8'h55, 8'h00, 8'h00, 8'h00);

        // Test 6: reset mid-drain.
        wr(2'd0, 8'h21); wr(2'd1, 8'h42);
        start_pulse();
        tick();
        Reset = 1'b1; DReady = 1'b0;
        tick();
        Reset = 1'b0;
        chk("t6_dvalid", 32'(DValid), 32'd0);
        chk("t6_busy", 32'(Busy), 32'd0);
        chk("t6_sum", 32'(Checksum), 32'd0);
        chk("t6_count", 32'(Count), 32'd0);
        start_pulse();
        chk("t6_err", 32'(StartErr), 32'd1);

        // Test 7: write and Start together on empty buffer.
        got.delete();
        WEB = 1'b1; AddrB = 2'd2; DataInB = 8'h33; Start = 1'b1;
        tick();
        WEB = 1'b0; Start = 1'b0;
        chk("t7_noerr", 32'(StartErr), 32'd0);
        DReady = 1'b1;
        wait_done("t7");
        expect_words("t7", 1, 8'h33, 8'h00, 8'h00, 8'h00);
        chk("t7_sum", 32'(Checksum), 32'h033);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_b_drain.md
Name: mc_b_drain

Overview:
- Downstream consumer of the memory-B write stream.
- Snoops every write the controller issues into MC_B (WEB/AddrB/DataInB) into a private 4-entry result buffer.
- On a Start pulse, streams the captured results out in ascending address order over a valid/ready handshake, accumulating a checksum and word count.
- Lets the rest of the system read transfer results without a second read port on MC_B.

Parameters:
DATA_W, 8, width of each result word (matches DataInB)
DEPTH, 4, number of buffer entries (matches MC_B depth)
ADDR_W, 2, buffer address width, log2(DEPTH)

Ports:
clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
WEB  input  1  memory-B write enable, snooped
AddrB  input  ADDR_W  memory-B write address, snooped
DataInB  input  DATA_W  memory-B write data, snooped
Start  input  1  one-cycle request to begin draining
DOut  output  DATA_W  drained result word
DValid  output  1  DOut holds a valid word
DReady  input  1  consumer accepts DOut this cycle
Busy  output  1  high while in DRAIN state
DrainDone  output  1  one-cycle pulse after the last word transfers
StartErr  output  1  one-cycle pulse when Start is seen with an empty buffer
Overrun  output  1  sticky: WEB seen while draining
Checksum  output  DATA_W+ADDR_W  unsigned sum of words drained in the current or last drain
Count  output  ADDR_W+1  number of words transferred in the current or last drain

Behaviour:
- Reset: synchronous, active-high, priority over all other inputs. On the clock edge where Reset=1:
  - FSM goes to COLLECT.
  - Valid mask is cleared; buffer contents are don't-care.
  - DOut=0, DValid=0, Busy=0, DrainDone=0, StartErr=0, Overrun=0, Checksum=0, Count=0.
- Reset mid-drain aborts the drain. Outputs show the reset values from the next cycle on.
- FSM has two states, COLLECT and DRAIN.
- COLLECT:
  - WEB=1: buf[AddrB] <= DataInB and mask[AddrB] <= 1.
  - Rewriting an already-valid address overwrites it; the last write wins.
  - Start=1 with mask (including a same-cycle write) nonzero:
    - Go to DRAIN.
    - Clear Checksum, Count and Overrun.
    - Load the pointer with the lowest valid address.
  - Start=1 with mask zero: pulse StartErr for 1 cycle; stay in COLLECT.
  - Simultaneous WEB and Start: the write is captured and is included in the drain.
- DRAIN:
  - Busy=1.
  - DValid is registered: it rises the cycle after Start is accepted, with DOut=buf[ptr].
  - A transfer occurs on any edge where DValid=1 and DReady=1. On a transfer:
    - Checksum += DOut (zero-extended, no overflow possible at defaults; max 4*255=1020 < 1024).
    - Count += 1.
    - mask[ptr] is cleared.
    - ptr moves to the next higher valid address, skipping invalid ones.
  - Back-to-back transfers are allowed: one word per cycle while DReady=1.
  - While DValid=1 and DReady=0, DOut and DValid hold stable.
  - After the last valid entry transfers:
    - DValid=0 and Busy=0.
    - Go to COLLECT.
    - DrainDone=1 for exactly that next cycle.
    - Checksum and Count hold until the next accepted Start or Reset.
  - WEB=1 in DRAIN: the write is ignored (not buffered) and Overrun is set. Overrun stays set until Reset or the next accepted Start.
  - Start in DRAIN is ignored.
- DReady is don't-care whenever DValid=0.
- No combinational path from any input to any output.

Test Plan:
- Reset=1 for 2 cycles, then writes to addr 0..3 of 8'h05, 8'hFA, 8'h10, 8'h03; Start with DReady=1 -> DOut 05, FA, 10, 03 on 4 consecutive cycles; DrainDone pulses once; Checksum=10'h112; Count=4.
- Same data with DReady held low for 3 cycles while DOut=8'hFA -> DOut/DValid stable for those 3 cycles; order and Checksum=10'h112 unchanged.
- Write only addr 1=8'h7F and addr 3=8'h80, plus addr 1 rewritten as 8'h01; Start -> exactly 2 words, 01 then 80; Count=2; Checksum=10'h081.
- Start with no writes since reset -> StartErr=1 for 1 cycle; DValid and Busy stay 0; state remains COLLECT; a later write plus Start drains normally.
- WEB=1 to addr 0 with 8'hAA during DRAIN -> Overrun=1 and stays set; 8'hAA is never output; the next accepted Start clears Overrun.
- Reset asserted while DValid=1 mid-drain -> next cycle DValid=0, Busy=0, Checksum=0, Count=0; an immediate Start gives StartErr (mask cleared).
- WEB and Start in the same cycle on an empty buffer (addr 2, 8'h33) -> drain of one word 8'h33; no StartErr.
